fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side drain stage placed directly downstream of `Asynchronous_FIFO`, clocked in the FIFO read domain. It pops 8-bit entries through the FIFO's `rd_en`/`empty`/`dout` port and packs PACK consecutive bytes into one wide word. Words leave through a valid/ready master interface. Partial words are emitted with a byte-keep mask on an idle timeout or an explicit flush.

## Interface
- DATA_WIDTH, 8, FIFO entry width (bits per lane)
- PACK, 4, lanes per output word (2..8)
- TIMEOUT, 16, idle cycles before a partial word is flushed; 0 disables the timeout

- rd_clk  in  1  FIFO read-domain clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop
- fifo_rd_en  out  1  FIFO pop strobe
- flush  in  1  single-cycle request to emit any partial word
- m_data  out  PACK*DATA_WIDTH  packed word; lane 0 = bits [DATA_WIDTH-1:0] = oldest byte
- m_keep  out  PACK  lane-valid mask
- m_last  out  1  word was closed by timeout or flush
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept

## Operation
- State:
  - assembly register asm[PACK lanes]
  - fill count cnt (0..PACK)
  - pend flag: a pop was issued last cycle, so its byte arrives this cycle
  - idle counter idle
  - flush_req latch
  - output register (m_data/m_keep/m_last/m_valid)
- Output register is free when `out_free = !m_valid || m_ready`.
- `close` is true in a cycle when any of these holds:
  - cnt==PACK and out_free
  - partial close: cnt>0, pend==0, out_free, and either (flush_req or flush) or (TIMEOUT!=0 and idle==TIMEOUT-1)
- Pop rule, combinational: `fifo_rd_en = !fifo_empty && ((cnt+pend < PACK) || (cnt==PACK && close)) && !(flush_req || flush)`.
- Pop gating:
  - Never pop while a flush is outstanding.
  - Never pop into a full asm unless it is closing this cycle.
- Capture: when pend, fifo_dout is written to lane cnt and cnt increments.
  - If close occurs in the same cycle, the byte goes to lane 0 of the fresh asm and cnt becomes 1.
- Close actions:
  - m_data ← asm; unfilled lanes are driven 0.
  - m_keep ← (1<<cnt)-1.
  - m_last ← 1 for a partial close, 0 for a full close.
  - m_valid ← 1.
  - cnt ← 0 (or 1 per the capture rule).
  - flush_req and idle are cleared.
- Transfer: m_valid clears on m_valid && m_ready unless a close reloads it the same cycle.
- Idle counter:
  - Increments each cycle with cnt>0, pend==0, fifo_empty.
  - Resets to 0 on any capture or close.
  - Saturates at TIMEOUT-1.
- Flush:
  - flush sets flush_req.
  - flush with cnt==0 and pend==0 emits nothing; flush_req clears the next cycle.
  - Flush while the output is full waits for out_free.
- Throughput: a full word every PACK+1 cycles when the FIFO is non-empty and m_ready=1.

## Timing
- Reset (rst_n low, asynchronous):
  - m_valid=0, m_data=0, m_keep=0, m_last=0.
  - cnt=0, pend=0, idle=0, flush_req=0.
  - fifo_rd_en is forced 0 while rst_n is low.
- Reset mid-operation discards the partial asm and any held output word. A byte popped in the reset cycle is lost; this is an accepted loss and the upstream FIFO is reset together with this block.
- Latency: pop at cycle t → byte captured at t+1 → earliest m_valid at t+2 after the PACK-th capture.
- Output stability: m_data/m_keep/m_last are held stable while m_valid && !m_ready.
- Backpressure: with m_valid=1, m_ready=0 and cnt==PACK, no pop is issued; no byte is ever dropped or duplicated.
- fifo_empty is sampled combinationally; the FIFO guarantees dout validity one cycle after the pop.

## Test plan
- Reset: hold rst_n=0 with fifo_empty=0 → fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0 throughout.
- Stream: FIFO holds 0x01..0x08, m_ready=1, PACK=4 → two words:
  - 0x04030201 with keep 0xF, last 0
  - 0x08070605 with keep 0xF, last 0
  - second word exactly 5 cycles after the first
- Backpressure: same data, m_ready=0 for 20 cycles → first word held stable, exactly 4 more pops (asm refilled) then fifo_rd_en=0; on m_ready=1 → 0x04030201 accepted first, then 0x08070605.
- Timeout: push 0xAA, 0xBB then FIFO stays empty, TIMEOUT=16 → m_data=0x0000BBAA, keep 0x3, last 1, asserted 16 cycles after the 0xBB capture.
- Flush: 3 bytes 0x11, 0x22, 0x33 captured, pulse flush → next cycle m_data=0x00332211, keep 0x7, last 1. A second flush with cnt=0 → no word.
- Reset mid-word: 2 bytes captured and m_valid=1, rst_n low for 1 cycle → m_valid drops immediately; the next 4 bytes produce a clean word with keep 0xF.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains byte entries from an async FIFO read port and packs
// PACK consecutive entries into one wide word on a valid/ready master port.
// Partial words leave with a keep mask on idle timeout or explicit flush.
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                       i_rd_clk,
    input  logic                       i_rst_n,
    input  logic                       i_fifo_empty,
    input  logic [DATA_WIDTH-1:0]      i_fifo_dout,
    output logic                       o_fifo_rd_en,
    input  logic                       i_flush,
    output logic [PACK*DATA_WIDTH-1:0] o_m_data,
    output logic [PACK-1:0]            o_m_keep,
    output logic                       o_m_last,
    output logic                       o_m_valid,
    input  logic                       i_m_ready
);

    localparam int unsigned CNT_W  = $clog2(PACK + 1);
    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(PACK);
    localparam logic [CNT_W:0]    FILL_LIM = (CNT_W + 1)'(PACK);
    localparam logic [IDLE_W-1:0] IDLE_MAX = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

    // Assembly state
    logic [PACK-1:0][DATA_WIDTH-1:0] r_asm;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_pend;
    logic                            r_flush_req;
    logic [IDLE_W-1:0]               r_idle;

    // Output register
    logic [PACK*DATA_WIDTH-1:0]      r_m_data;
    logic [PACK-1:0]                 r_m_keep;
    logic                            r_m_last;
    logic                            r_m_valid;

    // Combinational helpers
    logic                            w_out_free;
    logic                            w_flush_any;
    logic                            w_full;
    logic                            w_has_data;
    logic                            w_timeout_hit;
    logic                            w_close_full;
    logic                            w_close_part;
    logic                            w_close;
    logic [CNT_W:0]                  w_fill;
    logic                            w_room;
    logic [PACK-1:0]                 w_keep;
    logic [PACK*DATA_WIDTH-1:0]      w_data_masked;
    logic [PACK-1:0][DATA_WIDTH-1:0] w_asm_d;
    logic [CNT_W-1:0]                w_cnt_d;
    logic [IDLE_W-1:0]               w_idle_d;
    logic                            w_flush_req_d;

    assign w_out_free    = !r_m_valid || i_m_ready;
    assign w_flush_any   = r_flush_req || i_flush;
    assign w_full        = (r_cnt == CNT_FULL);
    assign w_has_data    = (r_cnt != '0);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_idle == IDLE_MAX);
    assign w_close_full  = w_full && w_out_free;
    // A partial close waits for any in-flight byte so it is not split off.
    assign w_close_part  = w_has_data && !w_full && !r_pend && w_out_free &&
                           (w_flush_any || w_timeout_hit);
    assign w_close       = w_close_full || w_close_part;

    // Bytes held plus the one in flight must leave room for another pop.
    assign w_fill        = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_pend};
    assign w_room        = (w_fill < FILL_LIM);
    assign o_fifo_rd_en  = i_rst_n && !i_fifo_empty && (w_room || w_close_full) && !w_flush_any;

    assign o_m_data  = r_m_data;
    assign o_m_keep  = r_m_keep;
    assign o_m_last  = r_m_last;
    assign o_m_valid = r_m_valid;

    // Build the outgoing word: filled lanes pass through, unfilled lanes read as zero.
    always_comb begin
        w_keep        = '0;
        w_data_masked = '0;
        for (int i = 0; i < PACK; i++) begin
            if (CNT_W'(i) < r_cnt) begin
                w_keep[i]                                   = 1'b1;
                w_data_masked[i*DATA_WIDTH +: DATA_WIDTH]   = r_asm[i];
            end
        end
    end

    // Next assembly contents and fill count, including capture into a freshly closed word.
    always_comb begin
        w_asm_d = r_asm;
        w_cnt_d = r_cnt;
        if (w_close) begin
            w_cnt_d = '0;
        end
        if (r_pend) begin
            if (w_close) begin
                w_asm_d[0] = i_fifo_dout;
                w_cnt_d    = CNT_W'(1);
            end else begin
                for (int i = 0; i < PACK; i++) begin
                    if (CNT_W'(i) == r_cnt) begin
                        w_asm_d[i] = i_fifo_dout;
                    end
                end
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end
    end

    // Idle counter and flush latch next state.
    always_comb begin
        w_idle_d = r_idle;
        if (r_pend || w_close) begin
            w_idle_d = '0;
        end else if (w_has_data && i_fifo_empty && (TIMEOUT != 0) && (r_idle != IDLE_MAX)) begin
            w_idle_d = r_idle + IDLE_W'(1);
        end

        // A flush with nothing held or in flight is simply dropped.
        if (w_close) begin
            w_flush_req_d = 1'b0;
        end else if (!w_has_data && !r_pend) begin
            w_flush_req_d = 1'b0;
        end else begin
            w_flush_req_d = w_flush_any;
        end
    end

    // State and output register update.
    always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_asm       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_flush_req <= 1'b0;
            r_idle      <= '0;
            r_m_data    <= '0;
            r_m_keep    <= '0;
            r_m_last    <= 1'b0;
            r_m_valid   <= 1'b0;
        end else begin
            r_asm       <= w_asm_d;
            r_cnt       <= w_cnt_d;
            r_pend      <= o_fifo_rd_en;
            r_flush_req <= w_flush_req_d;
            r_idle      <= w_idle_d;
            if (w_close) begin
                r_m_data  <= w_data_masked;
                r_m_keep  <= w_keep;
                r_m_last  <= w_close_part;
                r_m_valid <= 1'b1;
            end else if (i_m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios plus a randomized phase checked
// against a byte-stream model (every kept byte must match the popped order).
module tb_fifo_rd_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PK = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned WW = DW * PK;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_fifo_empty = 1'b1;
    logic [DW-1:0] i_fifo_dout = '0;
    logic          o_fifo_rd_en;
    logic          i_flush = 1'b0;
    logic [WW-1:0] o_m_data;
    logic [PK-1:0] o_m_keep;
    logic          o_m_last;
    logic          o_m_valid;
    logic          i_m_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PK),
        .TIMEOUT    (TO)
    ) dut (
        .i_rd_clk     (clk),
        .i_rst_n      (i_rst_n),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_dout  (i_fifo_dout),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_flush      (i_flush),
        .o_m_data     (o_m_data),
        .o_m_keep     (o_m_keep),
        .o_m_last     (o_m_last),
        .o_m_valid    (o_m_valid),
        .i_m_ready    (i_m_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int pops = 0;
    int n_acc = 0;
    int acc_cyc = 0;
    int last_pop_cyc = 0;
    bit acc_now = 0;
    bit stall_prev = 0;
    logic [WW-1:0] acc_data, prev_data;
    logic [PK-1:0] acc_keep, prev_keep;
    logic          acc_last, prev_last;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] popped_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        i_fifo_empty = 1'b0;
    endtask

    // Compare an accepted word against the next bytes of the popped stream.
    task automatic score();
        int n;
        logic [WW-1:0] exp_w;
        logic [PK-1:0] exp_k;
        n = 0;
        for (int i = 0; i < PK; i++) if (o_m_keep[i]) n++;
        exp_k = PK'((1 << n) - 1);
        check("keep_contiguous", 32'(o_m_keep), 32'(exp_k));
        check("keep_nonempty", 32'(n != 0), 32'd1);
        exp_w = '0;
        for (int i = 0; i < n; i++) begin
            check("byte_available", 32'(popped_q.size() != 0), 32'd1);
            if (popped_q.size() != 0) exp_w[i*DW +: DW] = popped_q.pop_front();
        end
        check("word_data", 32'(o_m_data), 32'(exp_w));
        check("word_last", 32'(o_m_last), 32'(n < int'(PK)));
    endtask

    // One clock: sample on the falling edge, advance the FIFO model after the rising edge.
    task automatic tick();
        bit pop_now;
        logic [DW-1:0] b;
        @(negedge clk);
        acc_now = 0;
        pop_now = o_fifo_rd_en;
        if (pop_now) begin
            check("pop_not_empty", 32'(i_fifo_empty), 32'd0);
            pops++;
            last_pop_cyc = cyc;
        end
        if (stall_prev) begin
            check("stall_valid", 32'(o_m_valid), 32'd1);
            check("stall_data", 32'(o_m_data), 32'(prev_data));
            check("stall_keep_last", 32'({o_m_keep, o_m_last}), 32'({prev_keep, prev_last}));
        end
        if (o_m_valid && i_m_ready) begin
            acc_now  = 1;
            acc_data = o_m_data;
            acc_keep = o_m_keep;
            acc_last = o_m_last;
            acc_cyc  = cyc;
            n_acc++;
            score();
        end
        stall_prev = o_m_valid && !i_m_ready;
        prev_data  = o_m_data;
        prev_keep  = o_m_keep;
        prev_last  = o_m_last;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_now && fifo_q.size() != 0) begin
            b = fifo_q.pop_front();
            i_fifo_dout = b;
            popped_q.push_back(b);
        end else begin
            i_fifo_dout = DW'($urandom);
        end
        i_fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic wait_accept(input string tag, input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            seen = acc_now;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_word(input string tag, input logic [WW-1:0] d, input logic [PK-1:0] k,
                              input logic l);
        check({tag, "_data"}, 32'(acc_data), 32'(d));
        check({tag, "_keep"}, 32'(acc_keep), 32'(k));
        check({tag, "_last"}, 32'(acc_last), 32'(l));
    endtask

    initial begin
        int c1;
        int base;
        int pp;

        // Reset with a non-empty FIFO
        for (int i = 1; i <= 8; i++) push_byte(DW'(i));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
            check("rst_valid", 32'(o_m_valid), 32'd0);
            check("rst_data", 32'(o_m_data), 32'd0);
            check("rst_keep", 32'(o_m_keep), 32'd0);
        end
        check("rst_last", 32'(o_m_last), 32'd0);
        i_rst_n = 1'b1;

        // Streaming at full rate
        i_m_ready = 1'b1;
        wait_accept("stream1", 30);
        check_word("stream1", 32'h0403_0201, 4'hF, 1'b0);
        c1 = acc_cyc;
        wait_accept("stream2", 30);
        check_word("stream2", 32'h0807_0605, 4'hF, 1'b0);
        check("stream_gap", 32'(acc_cyc - c1), 32'd5);
        for (int i = 0; i < 4; i++) tick();

        // Backpressure: output and assembly both full, no further pops
        i_m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push_byte(DW'(i));
        base = pops;
        for (int i = 0; i < 20; i++) tick();
        check("bp_pops", 32'(pops - base), 32'd8);
        check("bp_rd_en", 32'(o_fifo_rd_en), 32'd0);
        check("bp_valid", 32'(o_m_valid), 32'd1);
        check("bp_held", 32'(o_m_data), 32'h0403_0201);
        i_m_ready = 1'b1;
        wait_accept("bp1", 5);
        check_word("bp1", 32'h0403_0201, 4'hF, 1'b0);
        wait_accept("bp2", 5);
        check_word("bp2", 32'h0807_0605, 4'hF, 1'b0);
        wait_accept("bp3", 20);
        check_word("bp3", 32'h0C0B_0A09, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) tick();

        // Idle timeout closes a two-byte partial word
        push_byte(8'hAA);
        push_byte(8'hBB);
        wait_accept("timeout", 40);
        check_word("timeout", 32'h0000_BBAA, 4'h3, 1'b1);
        check("timeout_latency", 32'(acc_cyc - last_pop_cyc), 32'd18);
        for (int i = 0; i < 4; i++) tick();

        // Explicit flush of three bytes, then a flush with nothing held
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        for (int i = 0; i < 8; i++) tick();
        check("flush_pre_valid", 32'(o_m_valid), 32'd0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        check("flush_next_cycle", 32'(acc_now), 32'd1);
        check_word("flush", 32'h0033_2211, 4'h7, 1'b1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        base = n_acc;
        for (int i = 0; i < 25; i++) tick();
        check("empty_flush_words", 32'(n_acc - base), 32'd0);

        // Reset while a word is held and two bytes are assembled
        i_m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(DW'(8'h21 + i));
        for (int i = 0; i < 14; i++) tick();
        check("mid_valid_before", 32'(o_m_valid), 32'd1);
        i_rst_n = 1'b0;
        stall_prev = 0;
        #1;
        check("mid_valid_async", 32'(o_m_valid), 32'd0);
        popped_q.delete();
        tick();
        i_rst_n = 1'b1;
        i_m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(DW'(8'h31 + i));
        wait_accept("post_rst", 30);
        check_word("post_rst", 32'h3433_3231, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic, backpressure and flushes
        for (int seg = 0; seg < 12; seg++) begin
            pp = int'($urandom_range(0, 6));
            for (int k = 0; k < 250; k++) begin
                i_m_ready = ($urandom_range(0, 3) != 0);
                i_flush   = ($urandom_range(0, 59) == 0);
                if (seg % 4 == 3) begin
                    if ($urandom_range(0, 49) == 0) push_byte(DW'($urandom));
                end else if ($urandom_range(0, pp) == 0 && fifo_q.size() < 32) begin
                    for (int j = int'($urandom_range(1, 5)); j > 0; j--) push_byte(DW'($urandom));
                end
                tick();
            end
        end
        i_flush = 1'b0;
        i_m_ready = 1'b1;
        for (int k = 0; k < 500 && (fifo_q.size() != 0 || popped_q.size() != 0 || o_m_valid); k++)
            tick();
        check("drain_fifo", 32'(fifo_q.size()), 32'd0);
        check("drain_stream", 32'(popped_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish by 1ms, required finish");
        $fatal(1, "time limit");
    end

endmodule
